// File: rtl/button_conditioner.sv
// Push-button conditioner: 2-FF synchroniser, debounce FSM, and single-cycle
// press / release / long-press pulses for the downstream traffic-light controller.
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned HOLD_CYCLES     = 100_000_000,
    parameter int unsigned CNT_WIDTH       = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic hold_pulse
);

    localparam logic [CNT_WIDTH-1:0] DEB_LAST  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    logic                 s1;
    logic                 s2;
    state_t               state;
    state_t               state_n;
    logic [CNT_WIDTH-1:0] deb_cnt;
    logic [CNT_WIDTH-1:0] deb_cnt_n;
    logic [CNT_WIDTH-1:0] hold_cnt;
    logic [CNT_WIDTH-1:0] hold_cnt_n;
    logic                 hold_done;
    logic                 hold_done_n;
    logic                 btn_level_n;
    logic                 press_pulse_n;
    logic                 release_pulse_n;
    logic                 hold_pulse_n;

    // Metastability guard on the asynchronous pin
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn_raw;
            s2 <= s1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RELEASED;
            deb_cnt       <= '0;
            hold_cnt      <= '0;
            hold_done     <= 1'b0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            hold_pulse    <= 1'b0;
        end else begin
            state         <= state_n;
            deb_cnt       <= deb_cnt_n;
            hold_cnt      <= hold_cnt_n;
            hold_done     <= hold_done_n;
            btn_level     <= btn_level_n;
            press_pulse   <= press_pulse_n;
            release_pulse <= release_pulse_n;
            hold_pulse    <= hold_pulse_n;
        end
    end

    always_comb begin
        state_n         = state;
        deb_cnt_n       = deb_cnt;
        hold_cnt_n      = hold_cnt;
        hold_done_n     = hold_done;
        btn_level_n     = btn_level;
        press_pulse_n   = 1'b0;
        release_pulse_n = 1'b0;
        hold_pulse_n    = 1'b0;

        // Hold timer runs through release bounces; an accepted edge below overrides it
        if ((state == PRESSED || state == RELEASE_WAIT) && !hold_done) begin
            if (hold_cnt == HOLD_LAST) begin
                hold_pulse_n = 1'b1;
                hold_done_n  = 1'b1;
            end else begin
                hold_cnt_n = hold_cnt + 1'b1;
            end
        end

        case (state)
            RELEASED: begin
                if (s2) begin
                    state_n   = PRESS_WAIT;
                    deb_cnt_n = CNT_WIDTH'(1);
                end
            end
            PRESS_WAIT: begin
                if (!s2) begin
                    state_n   = RELEASED;
                    deb_cnt_n = '0;
                end else if (deb_cnt == DEB_LAST) begin
                    state_n       = PRESSED;
                    press_pulse_n = 1'b1;
                    btn_level_n   = 1'b1;
                    hold_cnt_n    = '0;
                    hold_done_n   = 1'b0;
                end else begin
                    deb_cnt_n = deb_cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (!s2) begin
                    state_n   = RELEASE_WAIT;
                    deb_cnt_n = CNT_WIDTH'(1);
                end
            end
            RELEASE_WAIT: begin
                if (s2) begin
                    state_n   = PRESSED;
                    deb_cnt_n = '0;
                end else if (deb_cnt == DEB_LAST) begin
                    state_n         = RELEASED;
                    release_pulse_n = 1'b1;
                    btn_level_n     = 1'b0;
                    hold_cnt_n      = '0;
                end else begin
                    deb_cnt_n = deb_cnt + 1'b1;
                end
            end
            default: begin
                state_n = RELEASED;
            end
        endcase
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: segment table of raw-pin levels with hand-derived
// pulse offsets, scored against observed pulses via an expected-event queue.
module tb_button_conditioner;

    localparam int unsigned DEB  = 4;
    localparam int unsigned HOLD = 20;
    localparam int unsigned CW   = 8;

    localparam int K_PRESS   = 0;
    localparam int K_RELEASE = 1;
    localparam int K_HOLD    = 2;

    typedef struct {
        logic v;
        int   len;
        int   p_off;
        int   r_off;
        int   h_off;
        logic lvl;
    } seg_t;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    logic btn_raw;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic hold_pulse;

    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    ev_t  exp_q[$];
    seg_t tbl[$];

    button_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .HOLD_CYCLES    (HOLD),
        .CNT_WIDTH      (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_raw      (btn_raw),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .hold_pulse   (hold_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        if (k == K_PRESS) return "press_pulse";
        if (k == K_RELEASE) return "release_pulse";
        return "hold_pulse";
    endfunction

    task automatic push_ev(input int k, input int c);
        ev_t e;
        int  idx;
        e.kind = k;
        e.cyc  = c;
        idx    = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i].cyc <= c) idx = i + 1;
        end
        exp_q.insert(idx, e);
    endtask

    task automatic check_pulse(input int k);
        int idx;
        idx = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i].kind == k && exp_q[i].cyc == cyc) idx = i;
        end
        total++;
        if (idx < 0) begin
            bad++;
            $display("FAIL %s: got 1 at cycle %0d, required 0 (unexpected pulse)", kname(k), cyc);
        end else begin
            exp_q.delete(idx);
        end
    endtask

    task automatic check_val(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b, required %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Pulse monitor: match every observed pulse, flag expected pulses that never came
    always @(posedge clk) begin
        #1;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            total++;
            bad++;
            $display("FAIL %s: got 0 at cycle %0d, required 1", kname(exp_q[0].kind), exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
        if (press_pulse === 1'b1) check_pulse(K_PRESS);
        if (release_pulse === 1'b1) check_pulse(K_RELEASE);
        if (hold_pulse === 1'b1) check_pulse(K_HOLD);
    end

    task automatic add_seg(input logic v, input int len, input int p, input int r, input int h,
                           input logic lvl);
        seg_t s;
        s.v     = v;
        s.len   = len;
        s.p_off = p;
        s.r_off = r;
        s.h_off = h;
        s.lvl   = lvl;
        tbl.push_back(s);
    endtask

    // Offsets are edge numbers within a segment (edge 1 is the first edge sampling s.v)
    task automatic apply_seg(input int idx, input seg_t s);
        int c0;
        c0 = cyc;
        if (s.p_off > 0) push_ev(K_PRESS, c0 + s.p_off);
        if (s.r_off > 0) push_ev(K_RELEASE, c0 + s.r_off);
        if (s.h_off > 0) push_ev(K_HOLD, c0 + s.h_off);
        for (int i = 0; i < s.len; i++) begin
            btn_raw = s.v;
            @(negedge clk);
        end
        check_val($sformatf("seg%0d btn_level", idx), btn_level, s.lvl);
    endtask

    initial begin
        int c0;

        // Short press: pulse on edge 6, released before the 20-cycle hold
        add_seg(1'b1, 16, 6, -1, -1, 1'b1);
        add_seg(1'b0, 12, -1, 6, -1, 1'b0);
        // Glitch of DEBOUNCE_CYCLES-1 samples is rejected
        add_seg(1'b1, 3, -1, -1, -1, 1'b0);
        add_seg(1'b0, 10, -1, -1, -1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            add_seg(1'b1, 1, -1, -1, -1, 1'b0);
            add_seg(1'b0, 1, -1, -1, -1, 1'b0);
        end
        add_seg(1'b0, 6, -1, -1, -1, 1'b0);
        // Release bounce: low 2, high 1, then low until accepted
        add_seg(1'b1, 10, 6, -1, -1, 1'b1);
        add_seg(1'b0, 2, -1, -1, -1, 1'b1);
        add_seg(1'b1, 1, -1, -1, -1, 1'b1);
        add_seg(1'b0, 12, -1, 6, -1, 1'b0);
        // Long press, single hold, then re-armed on the next press
        add_seg(1'b1, 60, 6, -1, 26, 1'b1);
        add_seg(1'b0, 12, -1, 6, -1, 1'b0);
        add_seg(1'b1, 40, 6, -1, 26, 1'b1);
        add_seg(1'b0, 12, -1, 6, -1, 1'b0);
        // Hold lands on the first RELEASE_WAIT cycle
        add_seg(1'b1, 23, 6, -1, 26, 1'b1);
        add_seg(1'b0, 12, -1, 6, -1, 1'b0);
        // Release bounce must not restart the hold timer
        add_seg(1'b1, 10, 6, -1, 26, 1'b1);
        add_seg(1'b0, 2, -1, -1, -1, 1'b1);
        add_seg(1'b1, 30, -1, -1, -1, 1'b1);
        add_seg(1'b0, 12, -1, 6, -1, 1'b0);

        rst     = 1'b1;
        btn_raw = 1'b0;
        repeat (3) @(negedge clk);
        check_val("reset btn_level", btn_level, 1'b0);
        check_val("reset press_pulse", press_pulse, 1'b0);
        check_val("reset release_pulse", release_pulse, 1'b0);
        check_val("reset hold_pulse", hold_pulse, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) apply_seg(i, tbl[i]);

        // Reset while pressed and still held: everything clears, then a fresh press
        apply_seg(100, '{1'b1, 10, 6, -1, -1, 1'b1});
        rst = 1'b1;
        @(negedge clk);
        check_val("midrst btn_level", btn_level, 1'b0);
        check_val("midrst press_pulse", press_pulse, 1'b0);
        check_val("midrst release_pulse", release_pulse, 1'b0);
        check_val("midrst hold_pulse", hold_pulse, 1'b0);
        rst = 1'b0;
        c0  = cyc;
        push_ev(K_PRESS, c0 + 6);
        repeat (12) @(negedge clk);
        check_val("post-reset btn_level", btn_level, 1'b1);
        apply_seg(101, '{1'b0, 12, -1, 6, -1, 1'b0});

        repeat (5) @(negedge clk);
        while (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL %s: got 0 at cycle %0d, required 1", kname(exp_q[0].kind), exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Conditions the raw, asynchronous push-button input. It synchronises, debounces and edge-detects the button.
- It produces clean single-cycle pulses for the traffic-light controller's start input, so the controller only ever sees one rising edge per physical press.
- It also reports release events and a long-press (hold) event, for use by mode or override logic.
- It sits directly upstream of the traffic-light controller, in the same 100 MHz clock domain.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, consecutive synchronised samples required to accept a level change (10 ms at 100 MHz); must be >= 2.
- HOLD_CYCLES, 100_000_000, cycles the debounced level must stay high to fire hold_pulse (1 s); must be > DEBOUNCE_CYCLES.
- CNT_WIDTH, 27, width of both internal counters; must satisfy 2^CNT_WIDTH > HOLD_CYCLES.

Ports:
- clk  input  1  system clock, 100 MHz; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- btn_raw  input  1  raw button pin, asynchronous, bouncy, active-high.
- btn_level  output  1  debounced button level.
- press_pulse  output  1  one-cycle pulse on each accepted press.
- release_pulse  output  1  one-cycle pulse on each accepted release.
- hold_pulse  output  1  one-cycle pulse, at most once per press, after HOLD_CYCLES.

Behaviour:
- Reset
  - Both synchroniser FFs = 0, state = RELEASED, deb_cnt = 0, hold_cnt = 0, hold_done = 0.
  - All outputs = 0.
  - Reset dominates every other event.
- Synchroniser: 2-FF chain btn_raw -> s1 -> s2. The FSM uses s2 only.
- FSM states: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT. All outputs are registered.
- RELEASED
  - s2=1 -> PRESS_WAIT, deb_cnt <= 1.
  - s2=0 -> stay.
- PRESS_WAIT
  - s2=0 -> RELEASED, deb_cnt <= 0. No pulse (glitch rejected).
  - s2=1 and deb_cnt == DEBOUNCE_CYCLES-1 -> PRESSED, press_pulse <= 1, btn_level <= 1, hold_cnt <= 0, hold_done <= 0.
  - Otherwise deb_cnt <= deb_cnt+1.
- PRESSED
  - s2=0 -> RELEASE_WAIT, deb_cnt <= 1.
  - s2=1 -> stay.
- RELEASE_WAIT
  - s2=1 -> PRESSED, deb_cnt <= 0. No pulse; btn_level stays 1.
  - s2=0 and deb_cnt == DEBOUNCE_CYCLES-1 -> RELEASED, release_pulse <= 1, btn_level <= 0, hold_cnt <= 0.
  - Otherwise deb_cnt <= deb_cnt+1.
- Latency
  - Press: with btn_raw stable high, press_pulse is high in the cycle following the (DEBOUNCE_CYCLES+2)-th rising edge that samples btn_raw=1.
  - Release is symmetric.
- Hold counter
  - Increments every cycle while in PRESSED or RELEASE_WAIT and hold_done=0.
  - When hold_cnt == HOLD_CYCLES-1: hold_pulse <= 1, hold_done <= 1, and the counter stops.
  - A bounce into RELEASE_WAIT does not clear hold_cnt; only an accepted release clears it.
- Pulse width: press_pulse, release_pulse and hold_pulse are each exactly 1 cycle, then 0.
- Simultaneous events
  - hold_pulse can coincide with the first cycle of RELEASE_WAIT; both actions occur.
  - press_pulse and release_pulse are never high in the same cycle.
- Reset mid-press
  - All state clears.
  - If the button is still held after reset deasserts, a full press debounce runs and press_pulse fires again (no suppression).
- Counters never wrap: deb_cnt is bounded by the FSM; hold_cnt freezes at HOLD_CYCLES-1.

Test Plan (DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, CNT_WIDTH=8):
- Clean press: after reset, btn_raw 0->1 and held.
  - Required: press_pulse=1 for exactly 1 cycle, after the 6th edge sampling btn_raw=1.
  - Required: btn_level rises in the same cycle as press_pulse.
  - Required: release_pulse=0 and hold_pulse=0 throughout.
- Glitch rejection:
  - btn_raw high for 3 cycles, then low -> no pulses, btn_level stays 0.
  - Alternating pattern 1,0,1,0 for 20 cycles -> no pulses.
- Bounce on release:
  - While pressed, btn_raw low 2 cycles, high 1, low 2 -> btn_level stays 1, no release_pulse.
  - Then btn_raw low 10 cycles -> exactly one release_pulse; btn_level falls with it.
- Long press: hold 60 cycles.
  - Required: exactly one press_pulse and exactly one hold_pulse, 20 cycles after press_pulse.
  - Required: no second hold_pulse.
  - Release then press again -> hold_pulse is re-armed and fires again.
- Reset mid-press:
  - Assert rst for 1 cycle while btn_level=1 and btn_raw held -> next cycle all outputs 0.
  - Afterwards press_pulse fires again 6 edges after rst deasserts.
- Short press before hold:
  - Press held 10 cycles past press_pulse, then released -> release_pulse and no hold_pulse.
